// File: rtl/data_sramlike_axi.sv
// Data-side sram-like to AXI3 bridge. One single-beat read or write is in
// flight at a time. Requests are accepted with zero wait in IDLE, and a
// registered data_ok pulse marks completion.
module data_sramlike_axi #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        bus_err
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs, wr_both;

    // Single-beat transfers never need the last flag.
    wire unused_ok = &{1'b0, rlast};

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    // Either channel may finish first; count a handshake in this cycle as done.
    assign wr_both = (aw_done | aw_hs) & (w_done | w_hs);

    // Fixed single-beat INCR attributes and the latched request fields.
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;
    assign araddr  = req_addr;
    assign awaddr  = req_addr;
    assign arsize  = {1'b0, req_size};
    assign awsize  = {1'b0, req_size};
    assign wdata   = req_wdata;
    assign wstrb   = req_strb;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_req) state_nxt = data_wr ? WR_REQ : RD_ADDR;
            RD_ADDR: if (arready)  state_nxt = RD_DATA;
            RD_DATA: if (rvalid)   state_nxt = IDLE;
            WR_REQ:  if (wr_both)  state_nxt = WR_RESP;
            WR_RESP: if (bvalid)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; the write channels drop independently.
    always_comb begin
        data_addr_ok = (state == IDLE) && data_req;
        arvalid      = (state == RD_ADDR);
        rready       = (state == RD_DATA);
        awvalid      = (state == WR_REQ) && !aw_done;
        wvalid       = (state == WR_REQ) && !w_done;
        bready       = (state == WR_RESP);
    end

    // Request capture, write-channel progress flags and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_size     <= 2'd0;
            req_addr     <= 32'd0;
            req_wdata    <= 32'd0;
            req_strb     <= 4'd0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            data_data_ok <= 1'b0;
            bus_err      <= 1'b0;
            data_rdata   <= 32'd0;
        end else begin
            data_data_ok <= 1'b0;
            bus_err      <= 1'b0;
            if (data_addr_ok) begin
                req_size  <= data_size;
                req_addr  <= data_addr;
                req_wdata <= data_wdata;
                case (data_size)
                    2'd0:    req_strb <= 4'b0001 << data_addr[1:0];
                    2'd1:    req_strb <= data_addr[1] ? 4'b1100 : 4'b0011;
                    default: req_strb <= 4'b1111;
                endcase
            end
            if (state == WR_REQ) begin
                if (wr_both) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                end
            end
            if (rready && rvalid) begin
                data_rdata   <= rdata;
                data_data_ok <= 1'b1;
                bus_err      <= (rresp != 2'b00);
            end
            if (bready && bvalid) begin
                data_data_ok <= 1'b1;
                bus_err      <= (bresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_data_sramlike_axi.sv
// Directed bench for data_sramlike_axi: a transaction-level model tracks which
// AXI channel handshakes are still owed and is compared every cycle, plus
// hand-computed literal checks for the scripted scenarios.
module tb_data_sramlike_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic        data_addr_ok, data_data_ok, bus_err;
    logic [31:0] data_rdata;
    logic [3:0]  arid, awid, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0, bresp = 2'd0;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    data_sramlike_axi dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-lane mask from access width and natural alignment of the address.
    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
        int nbytes, off;
        nbytes = (size >= 2) ? 4 : (1 << size);
        off    = int'(addr[1:0]) & ~(nbytes - 1);
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    // Transaction model: which handshakes the accepted request still owes.
    logic        m_ar = 0, m_r = 0, m_aw = 0, m_w = 0, m_b = 0;
    logic        m_ok = 0, m_err = 0;
    logic [1:0]  m_size = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    wire         m_busy = m_ar | m_r | m_aw | m_w | m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_ar, m_r, m_aw, m_w, m_b, m_ok, m_err} <= '0;
            m_size <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0;
        end else begin
            m_ok  <= 1'b0;
            m_err <= 1'b0;
            if (!m_busy && data_req) begin
                m_size <= data_size; m_addr <= data_addr; m_wdata <= data_wdata;
                if (data_wr) begin m_aw <= 1'b1; m_w <= 1'b1; end
                else         m_ar <= 1'b1;
            end else if (m_ar) begin
                if (arready) begin m_ar <= 1'b0; m_r <= 1'b1; end
            end else if (m_r) begin
                if (rvalid) begin
                    m_r <= 1'b0; m_rdata <= rdata; m_ok <= 1'b1; m_err <= (rresp != 0);
                end
            end else if (m_aw || m_w) begin
                m_aw <= m_aw && !awready;
                m_w  <= m_w && !wready;
                m_b  <= !(m_aw && !awready) && !(m_w && !wready);
            end else if (m_b) begin
                if (bvalid) begin
                    m_b <= 1'b0; m_ok <= 1'b1; m_err <= (bresp != 0);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("addr_ok", 32'(data_addr_ok), 32'(!m_busy && data_req));
            chk("arvalid", 32'(arvalid), 32'(m_ar));
            chk("rready",  32'(rready),  32'(m_r));
            chk("awvalid", 32'(awvalid), 32'(m_aw));
            chk("wvalid",  32'(wvalid),  32'(m_w));
            chk("bready",  32'(bready),  32'(m_b));
            chk("data_ok", 32'(data_data_ok), 32'(m_ok));
            chk("bus_err", 32'(bus_err), 32'(m_err));
            chk("rdata",   data_rdata, m_rdata);
            chk("fixed",   {arid, awid, wid, arlen[3:0], awlen[3:0], arburst, awburst, 3'b0, wlast},
                           {4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 2'b01, 2'b01, 3'b0, 1'b1});
            if (m_ar) begin
                chk("araddr", araddr, m_addr);
                chk("arsize", 32'(arsize), 32'(m_size));
            end
            if (m_aw) begin
                chk("awaddr", awaddr, m_addr);
                chk("awsize", 32'(awsize), 32'(m_size));
            end
            if (m_w) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", 32'(wstrb), 32'(m_strb(m_size, m_addr)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        data_req = 0; arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rresp = 0; bresp = 0;
    endtask

    task automatic set_req(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd);
        data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    endtask

    initial begin
        // Reset state.
        #3;
        chk("rst arvalid", 32'(arvalid), 0);
        chk("rst data_ok", 32'(data_data_ok), 0);
        chk("rst rdata", data_rdata, 0);
        chk("rst awvalid", 32'(awvalid), 0);
        cyc(); rst = 0; cmp_en = 1;
        cyc();

        // Word read: arready at 1, rvalid at 3, data_ok at 4.
        set_req(0, 2, 32'h1FC0_0010, 0);
        @(negedge clk); chk("rd addr_ok", 32'(data_addr_ok), 1);
        cyc(); idle_in(); arready = 1;
        @(negedge clk);
        chk("rd arvalid", 32'(arvalid), 1);
        chk("rd araddr", araddr, 32'h1FC0_0010);
        chk("rd arsize", 32'(arsize), 32'b010);
        cyc(); arready = 0;
        cyc(); rvalid = 1; rdata = 32'hDEAD_BEEF;
        cyc(); rvalid = 0;
        @(negedge clk);
        chk("rd data_ok", 32'(data_data_ok), 1);
        chk("rd data", data_rdata, 32'hDEAD_BEEF);
        cyc();

        // Byte write, awready two cycles before wready.
        set_req(1, 0, 32'h8000_0003, 32'h5500_0000);
        cyc(); idle_in(); awready = 1;
        @(negedge clk); chk("bw wstrb", 32'(wstrb), 32'b1000);
        cyc(); awready = 0;
        @(negedge clk);
        chk("bw awvalid dropped", 32'(awvalid), 0);
        chk("bw wvalid held", 32'(wvalid), 1);
        cyc(); wready = 1;
        cyc(); wready = 0; bvalid = 1;
        cyc(); bvalid = 0;
        @(negedge clk); chk("bw data_ok", 32'(data_data_ok), 1);
        cyc();

        // Half write, both handshakes in one cycle.
        set_req(1, 1, 32'h8000_0102, 32'hBEEF_0000);
        cyc(); idle_in(); awready = 1; wready = 1;
        @(negedge clk); chk("hw wstrb", 32'(wstrb), 32'b1100);
        cyc(); awready = 0; wready = 0; bvalid = 1;
        @(negedge clk); chk("hw bready", 32'(bready), 1);
        cyc(); bvalid = 0;
        @(negedge clk); chk("hw data_ok", 32'(data_data_ok), 1);
        cyc();

        // Backpressure with data_req held high throughout.
        set_req(0, 1, 32'h0000_1234, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("bp no addr_ok", 32'(data_addr_ok), 0);
            cyc();
        end
        chk("bp araddr", araddr, 32'h0000_1234);
        arready = 1;
        cyc(); arready = 0; rvalid = 1; rdata = 32'hA5A5_0F0F;
        cyc(); rvalid = 0; data_addr = 32'h0000_2000;
        @(negedge clk);
        chk("bp data_ok", 32'(data_data_ok), 1);
        chk("bp data", data_rdata, 32'hA5A5_0F0F);
        chk("bp next addr_ok", 32'(data_addr_ok), 1);
        cyc(); data_req = 0; arready = 1;
        cyc(); arready = 0; rvalid = 1; rdata = 32'h0BAD_F00D; rresp = 2'b01;
        cyc(); rvalid = 0; rresp = 0;
        @(negedge clk);
        chk("rerr data_ok", 32'(data_data_ok), 1);
        chk("rerr bus_err", 32'(bus_err), 1);
        cyc();

        // Write error response; next request accepted in the data_ok cycle.
        set_req(1, 2, 32'h0000_0100, 32'hCAFE_F00D);
        cyc(); idle_in(); awready = 1; wready = 1;
        cyc(); awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        cyc(); bvalid = 0; bresp = 0; set_req(0, 2, 32'h1FC0_0020, 0);
        @(negedge clk);
        chk("werr data_ok", 32'(data_data_ok), 1);
        chk("werr bus_err", 32'(bus_err), 1);
        chk("werr addr_ok", 32'(data_addr_ok), 1);
        cyc(); idle_in(); arready = 1;
        cyc(); arready = 0;
        @(negedge clk); chk("pre-rst rready", 32'(rready), 1);

        // Async reset in RD_DATA, between edges.
        #1 rst = 1;
        #1;
        chk("arst rready", 32'(rready), 0);
        chk("arst arvalid", 32'(arvalid), 0);
        chk("arst data_ok", 32'(data_data_ok), 0);
        chk("arst rdata", data_rdata, 0);
        cyc(); rst = 0;
        set_req(0, 2, 32'h0000_0040, 0);
        @(negedge clk); chk("post-rst addr_ok", 32'(data_addr_ok), 1);
        cyc(); idle_in();
        cyc(); arready = 1;
        cyc(); arready = 0; rvalid = 1; rdata = 32'h1234_5678;
        cyc(); rvalid = 0;
        @(negedge clk);
        chk("post-rst data_ok", 32'(data_data_ok), 1);
        chk("post-rst data", data_rdata, 32'h1234_5678);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
